// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga memory subsystem.
package tartaruga_pkg;

  localparam int unsigned LINE_OFFSET_BITS = 4;

  typedef logic [127:0] line_t;

  typedef enum logic {ARB_IC, ARB_DC} arb_owner_e;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 = icache, bit 1 = dcache, one-hot grant.
module rr_arbiter2
  import tartaruga_pkg::*;
(
  input  logic       [1:0] req_i,
  input  arb_owner_e       last_grant_i,
  output logic       [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie: favour whoever was not served last.
      2'b11:   gnt_o = (last_grant_i == ARB_DC) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/line_mem_arbiter.sv
// Shares one line-granular memory port between icache and dcache refill/writeback,
// one transaction outstanding, with a sticky response-timeout flag.
module line_mem_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_W      = 128,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_valid_i,
  output logic              ic_req_ready_o,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_rsp_valid_o,
  input  logic              ic_rsp_ready_i,
  output logic [ADDR_W-1:0] ic_rsp_addr_o,
  output logic [LINE_W-1:0] ic_rsp_line_o,
  input  logic              dc_req_valid_i,
  output logic              dc_req_ready_o,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_we_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_rsp_valid_o,
  input  logic              dc_rsp_ready_i,
  output logic [ADDR_W-1:0] dc_rsp_addr_o,
  output logic [LINE_W-1:0] dc_rsp_line_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [ADDR_W-1:0] mem_rsp_addr_i,
  input  logic [LINE_W-1:0] mem_rsp_line_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((1 << LINE_OFFSET_BITS) - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  arb_state_e        state_q;
  arb_owner_e        owner_q, last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;
  logic [CntW-1:0]   cnt_q, cnt_inc;
  logic              timeout_q, timeout_hit;
  logic [1:0]        gnt;
  logic              is_idle, in_wait, own_ic, own_dc, req_hs, rsp_hs, win_dc;

  rr_arbiter2 u_rr (
    .req_i        ({dc_req_valid_i, ic_req_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  always_comb begin
    is_idle = (state_q == ARB_IDLE);
    in_wait = (state_q == ARB_WAIT);
    own_ic  = in_wait && (owner_q == ARB_IC);
    own_dc  = in_wait && (owner_q == ARB_DC);
    win_dc  = gnt[1];

    ic_req_ready_o = is_idle && gnt[0];
    dc_req_ready_o = is_idle && gnt[1];
    req_hs = (ic_req_valid_i && ic_req_ready_o) || (dc_req_valid_i && dc_req_ready_o);

    ic_rsp_valid_o  = own_ic && mem_rsp_valid_i;
    dc_rsp_valid_o  = own_dc && mem_rsp_valid_i;
    ic_rsp_addr_o   = own_ic ? mem_rsp_addr_i : '0;
    ic_rsp_line_o   = own_ic ? mem_rsp_line_i : '0;
    dc_rsp_addr_o   = own_dc ? mem_rsp_addr_i : '0;
    dc_rsp_line_o   = own_dc ? mem_rsp_line_i : '0;
    mem_rsp_ready_o = (own_ic && ic_rsp_ready_i) || (own_dc && dc_rsp_ready_i);
    rsp_hs = mem_rsp_valid_i && mem_rsp_ready_o;

    mem_req_valid_o = (state_q == ARB_REQ);
    mem_addr_o      = addr_q;
    mem_we_o        = we_q;
    mem_wdata_o     = wdata_q;
    busy_o          = !is_idle;

    // Counting the current cycle lets the flag rise in the TIMEOUT_CYC-th busy cycle.
    cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    timeout_hit = busy_o && (cnt_inc == CntMax);
    timeout_o   = timeout_q || timeout_hit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_IC;
      last_grant_q <= ARB_DC;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (timeout_hit) timeout_q <= 1'b1;
      unique case (state_q)
        ARB_IDLE: begin
          if (req_hs) begin
            owner_q <= win_dc ? ARB_DC : ARB_IC;
            addr_q  <= (win_dc ? dc_addr_i : ic_addr_i) & ~OffMask;
            we_q    <= win_dc && dc_we_i;
            wdata_q <= win_dc ? dc_wdata_i : '0;
            cnt_q   <= '0;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          cnt_q <= cnt_inc;
          if (mem_req_ready_i) state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          cnt_q <= cnt_inc;
          if (rsp_hs) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= owner_q;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
